// File: rtl/partition_stats.sv
// partition_stats: one partition pass over a kernel buffer. Each accepted
// sample is compared against a captured 8-bit pivot. The block counts the
// samples in the lower, equal and larger partitions and tracks the min/max of
// the lower and larger partitions.
// Optional feature: define PARTITION_FORWARD_EN to add a one-entry forward
// register that passes each sample on, tagged with its destination partition.
// Without the macro, the fwd_* outputs are tied low and fwd_ready is ignored.
module partition_stats #(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [8:0]               in_pivot,
  input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
  input  logic [7:0]               in_samp,
  input  logic                     in_samp_valid,
  output logic                     in_samp_ready,
  output logic [7:0]               fwd_samp,
  output logic [1:0]               fwd_sel,
  output logic                     fwd_valid,
  input  logic                     fwd_ready,
  output logic [BUFF_SIZE_BIT-1:0] lower_size,
  output logic [BUFF_SIZE_BIT-1:0] equal_size,
  output logic [BUFF_SIZE_BIT-1:0] larger_size,
  output logic [8:0]               max_lower,
  output logic [8:0]               min_lower,
  output logic [8:0]               max_larger,
  output logic [8:0]               min_larger,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [BUFF_SIZE_BIT-1:0] CNT_ZERO = {BUFF_SIZE_BIT{1'b0}};
  localparam logic [BUFF_SIZE_BIT-1:0] CNT_ONE  = {{(BUFF_SIZE_BIT-1){1'b0}}, 1'b1};
  localparam logic [8:0] MAX_EMPTY = 9'h000;
  localparam logic [8:0] MIN_EMPTY = 9'h100;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [7:0]               pivot_r;
  logic [BUFF_SIZE_BIT-1:0] size_r;
  logic [BUFF_SIZE_BIT-1:0] acc_cnt_r;
  logic                     accept_s;
  logic                     all_taken_s;
  logic                     last_accept_s;
  logic                     drain_ok_s;
  logic [8:0]               samp_ext_s;
  logic                     samp_lt_s;
  logic                     samp_eq_s;

  assign accept_s      = in_samp_valid && in_samp_ready;
  assign all_taken_s   = (acc_cnt_r == size_r);
  assign last_accept_s = accept_s && ((acc_cnt_r + CNT_ONE) == size_r);
  assign samp_ext_s    = {1'b0, in_samp};
  assign samp_lt_s     = (in_samp < pivot_r);
  assign samp_eq_s     = (in_samp == pivot_r);

`ifdef PARTITION_FORWARD_EN
  logic unused_s;
  assign unused_s   = in_pivot[8];
  // A new sample may enter only when the forward slot is free or emptying now.
  assign drain_ok_s = !fwd_valid || fwd_ready;

  // Forward register: load each accepted sample, clear once it is taken.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fwd_valid <= 1'b0;
      fwd_samp  <= 8'd0;
      fwd_sel   <= 2'b00;
    end else if (accept_s) begin
      fwd_valid <= 1'b1;
      fwd_samp  <= in_samp;
      fwd_sel   <= samp_lt_s ? 2'b00 : (samp_eq_s ? 2'b01 : 2'b10);
    end else if (fwd_ready) begin
      fwd_valid <= 1'b0;
    end else begin
      fwd_valid <= fwd_valid;
    end
  end
`else
  logic unused_s;
  assign unused_s   = ^{fwd_ready, in_pivot[8]};
  assign drain_ok_s = 1'b1;
  assign fwd_valid  = 1'b0;
  assign fwd_samp   = 8'd0;
  assign fwd_sel    = 2'b00;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the pass ends only when the last sample has left the forward slot.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = (in_buff_size == CNT_ZERO) ? DONE : SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
`ifdef PARTITION_FORWARD_EN
        if (all_taken_s && !fwd_valid) begin
          state_nxt_s = DONE;
        end else if (all_taken_s && fwd_ready) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SCAN;
        end
`else
        if (last_accept_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SCAN;
        end
`endif
      end
      DONE: begin
        if (res_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    in_samp_ready = 1'b0;
    res_valid     = 1'b0;
    busy          = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      SCAN: begin
        busy          = 1'b1;
        in_samp_ready = !all_taken_s && drain_ok_s;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Statistics datapath: cleared on start, updated per accepted sample, held otherwise.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pivot_r     <= 8'd0;
      size_r      <= CNT_ZERO;
      acc_cnt_r   <= CNT_ZERO;
      lower_size  <= CNT_ZERO;
      equal_size  <= CNT_ZERO;
      larger_size <= CNT_ZERO;
      max_lower   <= MAX_EMPTY;
      min_lower   <= MIN_EMPTY;
      max_larger  <= MAX_EMPTY;
      min_larger  <= MIN_EMPTY;
    end else if ((state_r == IDLE) && start) begin
      pivot_r     <= in_pivot[7:0];
      size_r      <= in_buff_size;
      acc_cnt_r   <= CNT_ZERO;
      lower_size  <= CNT_ZERO;
      equal_size  <= CNT_ZERO;
      larger_size <= CNT_ZERO;
      max_lower   <= MAX_EMPTY;
      min_lower   <= MIN_EMPTY;
      max_larger  <= MAX_EMPTY;
      min_larger  <= MIN_EMPTY;
    end else if (accept_s) begin
      acc_cnt_r <= acc_cnt_r + CNT_ONE;
      if (samp_lt_s) begin
        lower_size <= lower_size + CNT_ONE;
        if (samp_ext_s > max_lower) max_lower <= samp_ext_s;
        if (samp_ext_s < min_lower) min_lower <= samp_ext_s;
      end else if (samp_eq_s) begin
        equal_size <= equal_size + CNT_ONE;
      end else begin
        larger_size <= larger_size + CNT_ONE;
        if (samp_ext_s > max_larger) max_larger <= samp_ext_s;
        if (samp_ext_s < min_larger) min_larger <= samp_ext_s;
      end
    end else begin
      acc_cnt_r <= acc_cnt_r;
    end
  end

endmodule

// File: tb/tb_partition_stats.sv
// Directed bench for partition_stats with hand-computed expected values.
// Build with PARTITION_FORWARD_EN to also exercise the forward register.
module tb_partition_stats;

  logic       clock = 1'b0;
  logic       reset, start, in_samp_valid, fwd_ready, res_ready;
  logic [8:0] in_pivot;
  logic [5:0] in_buff_size;
  logic [7:0] in_samp;
  logic       in_samp_ready, fwd_valid, busy, res_valid;
  logic [7:0] fwd_samp;
  logic [1:0] fwd_sel;
  logic [5:0] lower_size, equal_size, larger_size;
  logic [8:0] max_lower, min_lower, max_larger, min_larger;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  partition_stats #(.BUFF_SIZE(32), .BUFF_SIZE_BIT(6)) dut (
    .clock(clock), .reset(reset), .start(start), .in_pivot(in_pivot),
    .in_buff_size(in_buff_size), .in_samp(in_samp), .in_samp_valid(in_samp_valid),
    .in_samp_ready(in_samp_ready), .fwd_samp(fwd_samp), .fwd_sel(fwd_sel),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .lower_size(lower_size),
    .equal_size(equal_size), .larger_size(larger_size), .max_lower(max_lower),
    .min_lower(min_lower), .max_larger(max_larger), .min_larger(min_larger),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pass(input logic [8:0] piv, input logic [5:0] sz);
    in_pivot     = piv;
    in_buff_size = sz;
    start        = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one sample and hold it until the DUT takes it (bounded wait).
  task automatic feed(input logic [7:0] s);
    int b;
    in_samp       = s;
    in_samp_valid = 1'b1;
    b = 0;
    while (!in_samp_ready && b < 50) begin
      step();
      b++;
    end
    if (!in_samp_ready) check_eq("feed_ready_timeout", 32'(in_samp_ready), 32'd1);
    step();
    in_samp_valid = 1'b0;
  endtask

  // Results must be valid the cycle after the last accept (one more with forwarding).
  task automatic wait_result(input string tag);
`ifdef PARTITION_FORWARD_EN
    for (int i = 0; i < 3; i++) begin
      if (!res_valid) step();
    end
`endif
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd1);
  endtask

  task automatic check_stats(input string tag, input int lo, input int eq, input int la,
                             input int mxl, input int mnl, input int mxg, input int mng);
    check_eq({tag, "_lower_size"},  32'(lower_size),  32'(lo));
    check_eq({tag, "_equal_size"},  32'(equal_size),  32'(eq));
    check_eq({tag, "_larger_size"}, 32'(larger_size), 32'(la));
    check_eq({tag, "_max_lower"},   32'(max_lower),   32'(mxl));
    check_eq({tag, "_min_lower"},   32'(min_lower),   32'(mnl));
    check_eq({tag, "_max_larger"},  32'(max_larger),  32'(mxg));
    check_eq({tag, "_min_larger"},  32'(min_larger),  32'(mng));
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_eq({tag, "_busy_after"},  32'(busy),      32'd0);
    check_eq({tag, "_valid_after"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b0; start = 1'b0; in_samp_valid = 1'b0; fwd_ready = 1'b1; res_ready = 1'b0;
    in_pivot = 9'd0; in_buff_size = 6'd0; in_samp = 8'd0;
    step(); step();

    // Reset state
    check_eq("rst_ready", 32'(in_samp_ready), 32'd0);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    check_eq("rst_fwd_samp", 32'(fwd_samp), 32'd0);
    check_eq("rst_fwd_sel", 32'(fwd_sel), 32'd0);
    check_stats("rst", 0, 0, 0, 0, 256, 0, 256);
    reset = 1'b1;
    step();

    // Mixed pass: pivot 100, samples 50,100,150,20
    start_pass(9'd100, 6'd4);
    check_eq("a_busy", 32'(busy), 32'd1);
    check_eq("a_ready", 32'(in_samp_ready), 32'd1);
    feed(8'd50); feed(8'd100); feed(8'd150);
    check_eq("a_early_valid", 32'(res_valid), 32'd0);
    feed(8'd20);
    wait_result("a");
    check_stats("a", 2, 1, 1, 50, 20, 150, 150);
`ifndef PARTITION_FORWARD_EN
    check_eq("a_fwd_tied", 32'(fwd_valid), 32'd0);
`endif
    consume("a");

    // All equal; then result held under res_ready=0 with an ignored start
    start_pass(9'd10, 6'd3);
    feed(8'd10); feed(8'd10); feed(8'd10);
    wait_result("b");
    check_stats("b", 0, 3, 0, 0, 256, 0, 256);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_pivot = 9'd200; in_buff_size = 6'd1; start = 1'b1;
      end
      step();
      start = 1'b0;
      check_eq("hold_res_valid", 32'(res_valid), 32'd1);
      check_eq("hold_busy", 32'(busy), 32'd1);
      check_eq("hold_equal", 32'(equal_size), 32'd3);
      check_eq("hold_ready", 32'(in_samp_ready), 32'd0);
    end
    consume("b");
    step(); step();
    check_stats("idle_hold", 0, 3, 0, 0, 256, 0, 256);

    // Zero-size pass goes straight to DONE
    start_pass(9'd7, 6'd0);
    check_eq("z_res_valid", 32'(res_valid), 32'd1);
    check_eq("z_ready", 32'(in_samp_ready), 32'd0);
    check_eq("z_busy", 32'(busy), 32'd1);
    check_stats("z", 0, 0, 0, 0, 256, 0, 256);
    consume("z");

    // Full buffer of 32 samples, no counter wrap
    start_pass(9'd0, 6'd32);
    for (int i = 0; i < 32; i++) feed(8'(i));
    wait_result("full");
    check_stats("full", 0, 1, 31, 0, 256, 31, 1);
    consume("full");

    // Pivot bit 8 ignored, idle gap between samples
    start_pass(9'h180, 6'd2);
    feed(8'd127);
    step();
    check_eq("gap_res_valid", 32'(res_valid), 32'd0);
    check_eq("gap_busy", 32'(busy), 32'd1);
    feed(8'd128);
    wait_result("bit8");
    check_stats("bit8", 1, 1, 0, 127, 127, 0, 256);
    consume("bit8");

    // Reset in the middle of a pass
    start_pass(9'd50, 6'd8);
    feed(8'd10); feed(8'd60);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_res_valid", 32'(res_valid), 32'd0);
    check_eq("mr_ready", 32'(in_samp_ready), 32'd0);
    check_stats("mr", 0, 0, 0, 0, 256, 0, 256);
    seen = 1'b0;
    in_samp = 8'd33; in_samp_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (res_valid) seen = 1'b1;
    end
    in_samp_valid = 1'b0;
    check_eq("mr_no_result", 32'(seen), 32'd0);
    start_pass(9'd5, 6'd2);
    feed(8'd1); feed(8'd9);
    wait_result("mr_new");
    check_stats("mr_new", 1, 0, 1, 1, 1, 9, 9);
    consume("mr_new");

`ifdef PARTITION_FORWARD_EN
    // Forward backpressure holds the first sample
    fwd_ready = 1'b0;
    start_pass(9'd100, 6'd3);
    feed(8'd150);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_fwd_valid", 32'(fwd_valid), 32'd1);
      check_eq("bp_fwd_samp", 32'(fwd_samp), 32'd150);
      check_eq("bp_fwd_sel", 32'(fwd_sel), 32'd2);
      check_eq("bp_ready", 32'(in_samp_ready), 32'd0);
      step();
    end
    fwd_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_samp_ready), 32'd1);
    feed(8'd20);
    check_eq("bp_fwd_sel2", 32'(fwd_sel), 32'd0);
    feed(8'd100);
    wait_result("bp");
    check_stats("bp", 1, 1, 1, 20, 20, 150, 150);
    check_eq("bp_fwd_empty", 32'(fwd_valid), 32'd0);
    consume("bp");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
